dq_wr_burst_seq: RTL and testbench
==================================

// Module: dq_wr_burst_seq
// PURPOSE
//  Write-burst sequencer for one DDR3 byte lane built on 4:1 DDR output serdes.
//  Accepts BL8 write commands and, after a programmable latency, drives the
//  DQS/DQ serdes parallel data and tristate inputs in the clk_div domain.
//  Generates preamble, burst and postamble, and the write-data fetch strobe.
//  Back-to-back bursts merge gaplessly.
// PARAMETERS
//  NUM_DQ     8  DQ bits in the lane.
//  WLAT_BITS  4  width of wlat; max latency 2**WLAT_BITS-1 clk_div cycles.
// PORTS
//  clk_div    in   1           serdes parallel clock (clk/2); sole clock
//  rst_n      in   1           async active-low reset
//  wlat       in   WLAT_BITS   write latency (clk_div cycles); change only while busy=0
//  cmd_valid  in   1           write command request
//  cmd_ready  out  1           command accepted when cmd_valid & cmd_ready
//  wdata_req  out  1           fetch strobe; wdata sampled at end of this cycle
//  wdata      in   4*NUM_DQ    beat data; bits [4i+3:4i] -> DQ i, bit 4i first in time
//  dq_din     out  4*NUM_DQ    to DQ serdes din
//  dq_tin     out  4           to DQ serdes tin (shared; 1 = high-Z)
//  dqs_din    out  4           to DQS serdes din
//  dqs_tin    out  4           to DQS serdes tin
//  busy       out  1           command pending or DQS driven
// BEHAVIOUR
//  Reset (async, any time, incl. mid-burst): pending commands dropped; dq_din=0,
//   dq_tin=4'hF, dqs_din=0, dqs_tin=4'hF, wdata_req=0, busy=0, cmd_ready=1.
//   All outputs registered. Bit 0 of every 4-bit group is first on the wire.
//  Schedule: shift register, 2**WLAT_BITS+1 entries, shifts one entry per cycle.
//   Accept in cycle A marks the entry for burst start at A+wlat+2. Each burst
//   has two data cycles: B0=A+wlat+2, B1=A+wlat+3.
//  cmd_ready = ~accepted_last_cycle. Minimum command spacing is 2 cycles, so
//   bursts never overlap. Spacing 2 gives gapless bursts.
//  wdata_req: high in cycles B0-1 and B1-1. wdata sampled then appears on dq_din
//   in the next cycle (1-cycle latency). wdata ignored when wdata_req=0.
//  Per output cycle, priority burst > preamble > postamble > idle:
//   burst (B0/B1): dqs_din=4'b0101, dqs_tin=4'h0, dq_tin=4'h0, dq_din=wdata reg.
//   preamble (cycle before B0, not a burst cycle): dqs_din=0, dqs_tin=4'b0011
//    (first tCK high-Z, second tCK driven low), dq_tin=4'hF.
//   postamble (cycle after B1, not burst or preamble): dqs_din=0,
//    dqs_tin=4'b1100 (driven low 1 tCK, then high-Z), dq_tin=4'hF.
//   idle: dqs_din=0, dqs_tin=4'hF, dq_tin=4'hF, dq_din=0.
//  Gapless case: the next preamble/postamble is replaced by burst cycles, so
//   DQS toggles continuously.
//  Burst 2 cycles after the previous B1 (1-cycle gap): that gap cycle is both
//   preamble and postamble. Preamble rules apply, with dqs_tin=4'h0
//   (DQS held low for the whole cycle).
//  busy = any schedule entry set, or current/next output cycle not idle.
//  wlat=0: preamble in A+1, B0 in A+2. wlat change while busy=1 is unsupported.
// CONFIGURATION
//  WSEQ_ODT_EN defined: adds output odt (1 bit, reset 0). odt is high in every
//   preamble, burst and postamble cycle, aligned with dqs_tin.
//  WSEQ_ODT_EN not defined: port and logic absent; other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 mid-burst -> all outputs at reset values immediately.
//    After release, cmd_ready=1 and busy=0.
//  2 wlat=3, single cmd at A=10 -> wdata_req @14,15; preamble @14;
//    burst @15,16 with dq_din=sampled wdata; postamble @17; busy=0 @18.
//  3 wlat=0, cmds at A=5 and A=7 -> cmd_ready=0 @6. Bursts @7-10 gapless,
//    dqs_din=4'b0101 throughout; one preamble @6, one postamble @11.
//  4 wlat=2, cmds at A=0 and A=3 -> gap cycle @6: dqs_tin=4'h0, dqs_din=0,
//    dq_tin=4'hF.
//  5 wdata pattern 32'h8421_F00F, wdata_req=0 cycles with random wdata ->
//    dq_din lane mapping exact; random data never reaches dq_din.
//  6 WSEQ_ODT_EN build, scenario 2 -> odt high @14-17 only.

Source files
------------

// File: rtl/dq_wr_burst_seq.sv
// dq_wr_burst_seq: write-burst sequencer for one DDR3 byte lane driving 4:1 DDR output serdes.
// Accepts BL8 write commands. After a programmable latency it drives the DQS/DQ serdes
// parallel data and tristate inputs in the clk_div domain. It generates the preamble,
// the burst, the postamble and the write-data fetch strobe. Back-to-back bursts merge
// without a gap.
//
// Optional feature: define WSEQ_ODT_EN to add the odt output. odt is high in every
// preamble, burst and postamble cycle.
//
// Ports:
//   clk_div    serdes parallel clock (clk/2); the only clock
//   rst_n      asynchronous active-low reset
//   wlat       write latency in clk_div cycles; change only while busy = 0
//   cmd_valid  write command request
//   cmd_ready  command accepted when cmd_valid & cmd_ready
//   wdata_req  fetch strobe; wdata is sampled at the end of this cycle
//   wdata      beat data; bits [4i+3:4i] go to DQ i, and bit 4i is first in time
//   dq_din     to DQ serdes din
//   dq_tin     to DQ serdes tin (shared by all DQ; 1 = high-Z)
//   dqs_din    to DQS serdes din
//   dqs_tin    to DQS serdes tin
//   odt        (WSEQ_ODT_EN only) termination enable, aligned with dqs_tin
//   busy       a command is pending or DQS is driven
// Every output is registered. Bit 0 of each 4-bit group is first on the wire.
module dq_wr_burst_seq #(
  parameter int unsigned NUM_DQ    = 8,
  parameter int unsigned WLAT_BITS = 4
) (
  input  logic                  clk_div,
  input  logic                  rst_n,
  input  logic [WLAT_BITS-1:0]  wlat,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  wdata_req,
  input  logic [4*NUM_DQ-1:0]   wdata,
  output logic [4*NUM_DQ-1:0]   dq_din,
  output logic [3:0]            dq_tin,
  output logic [3:0]            dqs_din,
  output logic [3:0]            dqs_tin,
`ifdef WSEQ_ODT_EN
  output logic                  odt,
`endif
  output logic                  busy
);

  localparam int unsigned Depth = 2**WLAT_BITS + 1;

  // During cycle c, sched_q[k] means that a burst's first data cycle (B0) falls in cycle c+1+k.
  logic [Depth-1:0] sched_q, sched_d;
  // b0_cur_q: cycle c is a B0. b0_prev_q: cycle c-1 was a B0.
  logic             b0_cur_q, b0_prev_q;

  logic             accept;
  // Flags describing the output cycle n = c+1 that is computed at the end of cycle c.
  logic             b0_n, b0_np1, b0_nm1, b0_nm2;
  logic             is_burst, is_pre, is_post;

  logic                 cmd_ready_d, wdata_req_d, busy_d;
  logic [4*NUM_DQ-1:0]  dq_din_d;
  logic [3:0]           dq_tin_d, dqs_din_d, dqs_tin_d;
`ifdef WSEQ_ODT_EN
  logic                 odt_d;
`endif

  // State register
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      sched_q   <= '0;
      b0_cur_q  <= 1'b0;
      b0_prev_q <= 1'b0;
      cmd_ready <= 1'b1;
      wdata_req <= 1'b0;
      busy      <= 1'b0;
      dq_din    <= '0;
      dq_tin    <= 4'hF;
      dqs_din   <= 4'h0;
      dqs_tin   <= 4'hF;
`ifdef WSEQ_ODT_EN
      odt       <= 1'b0;
`endif
    end else begin
      sched_q   <= sched_d;
      b0_cur_q  <= b0_n;
      b0_prev_q <= b0_cur_q;
      cmd_ready <= cmd_ready_d;
      wdata_req <= wdata_req_d;
      busy      <= busy_d;
      dq_din    <= dq_din_d;
      dq_tin    <= dq_tin_d;
      dqs_din   <= dqs_din_d;
      dqs_tin   <= dqs_tin_d;
`ifdef WSEQ_ODT_EN
      odt       <= odt_d;
`endif
    end
  end

  // Next-state: advance the schedule and insert a newly accepted command.
  always_comb begin
    accept  = cmd_valid & cmd_ready;
    sched_d = sched_q >> 1;
    // An accept in cycle A places B0 at A+wlat+2. Relative to the next cycle, that is index wlat.
    if (accept) sched_d[wlat] = 1'b1;
    b0_n   = sched_q[0];
    b0_np1 = sched_d[0];
    b0_nm1 = b0_cur_q;
    b0_nm2 = b0_prev_q;
  end

  // Outputs for the next cycle. Priority order: burst, then preamble, then postamble, then idle.
  always_comb begin
    is_burst = b0_n | b0_nm1;
    is_pre   = b0_np1 & ~is_burst;
    is_post  = b0_nm2 & ~is_burst;

    cmd_ready_d = ~accept;
    wdata_req_d = b0_np1 | b0_n;
    busy_d      = (|sched_d) | b0_n | b0_nm1 | b0_nm2;
    // Data fetched in the previous cycle appears on the wire now. Otherwise the output is 0.
    dq_din_d    = wdata_req ? wdata : '0;

    dqs_din_d = 4'h0;
    dqs_tin_d = 4'hF;
    dq_tin_d  = 4'hF;
    if (is_burst) begin
      dqs_din_d = 4'b0101;
      dqs_tin_d = 4'h0;
      dq_tin_d  = 4'h0;
    end else if (is_pre && is_post) begin
      // A one-cycle gap between bursts keeps DQS driven low for the whole cycle.
      dqs_tin_d = 4'h0;
    end else if (is_pre) begin
      dqs_tin_d = 4'b0011;
    end else if (is_post) begin
      dqs_tin_d = 4'b1100;
    end
`ifdef WSEQ_ODT_EN
    odt_d = is_burst | is_pre | is_post;
`endif
  end

endmodule

// File: tb/tb_dq_wr_burst_seq.sv
module tb_dq_wr_burst_seq;
  localparam int NDQ = 8;
  localparam int WB  = 4;
  localparam int N   = 4096;
  localparam logic [31:0] P0 = 32'h8421_F00F;
  localparam logic [31:0] P1 = 32'h1234_5678;

  logic          clk_div = 1'b0;
  logic          rst_n = 1'b0;
  logic [WB-1:0] wlat = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready, wdata_req, busy;
  logic [31:0]   wdata = '0;
  logic [31:0]   dq_din;
  logic [3:0]    dq_tin, dqs_din, dqs_tin;
`ifdef WSEQ_ODT_EN
  logic          odt;
`endif

  always #5 clk_div = ~clk_div;

  dq_wr_burst_seq #(.NUM_DQ(NDQ), .WLAT_BITS(WB)) dut (
    .clk_div(clk_div), .rst_n(rst_n), .wlat(wlat), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .wdata_req(wdata_req), .wdata(wdata), .dq_din(dq_din),
    .dq_tin(dq_tin), .dqs_din(dqs_din), .dqs_tin(dqs_tin),
`ifdef WSEQ_ODT_EN
    .odt(odt),
`endif
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cyc0 = 0;

  // Reference model, indexed by absolute cycle number.
  bit          acc_m  [N];
  bit          b0_m   [N];
  bit          wreq_m [N];
  logic [31:0] wd_m   [N];

  // Values observed in the current directed scenario, indexed by relative cycle.
  logic        o_wreq [64];
  logic        o_busy [64];
  logic        o_rdy  [64];
  logic [3:0]  o_tin  [64];
  logic [3:0]  o_din  [64];
  logic [3:0]  o_dqt  [64];
  logic [31:0] o_dq   [64];

  typedef struct {
    int          scen;
    int          rel;
    logic        wreq;
    logic [3:0]  tin;
    logic [3:0]  din;
    logic [3:0]  dqt;
    logic        bsy;
    logic        rdy;
    bit          chk_dq;
    logic [31:0] dq;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit xb(int m);
    return (m >= 0 && m < N) ? b0_m[m] : 1'b0;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < N; i++) begin
      acc_m[i] = 0; b0_m[i] = 0; wreq_m[i] = 0; wd_m[i] = '0;
    end
  endfunction

  // Runs one clock cycle: drive the inputs, then check every output against the model at the negedge.
  task automatic step(input bit v, input logic [31:0] d);
    int n;
    bit burst, pre, post, e_rdy, e_wreq, e_busy;
    logic [3:0] e_tin;
    logic [31:0] e_dq;
    @(posedge clk_div);
    cyc++;
    #1;
    cmd_valid = v;
    wdata = d;
    @(negedge clk_div);
    n = cyc;
    burst  = xb(n) | xb(n-1);
    pre    = xb(n+1) & !burst;
    post   = xb(n-2) & !burst;
    e_rdy  = !(n > 0 && acc_m[n-1]);
    e_wreq = xb(n+1) | xb(n);
    e_busy = 0;
    for (int a = (n > 25 ? n-25 : 0); a < n; a++)
      if (acc_m[a] && n <= a + int'(wlat) + 4) e_busy = 1;
    e_dq  = (n > 0 && wreq_m[n-1]) ? wd_m[n-1] : 32'h0;
    e_tin = burst ? 4'h0 : (pre && post) ? 4'h0 : pre ? 4'h3 : post ? 4'hC : 4'hF;
    chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, e_rdy});
    chk("busy", {31'b0, busy}, {31'b0, e_busy});
    chk("wdata_req", {31'b0, wdata_req}, {31'b0, e_wreq});
    chk("dq_din", dq_din, e_dq);
    chk("dq_tin", {28'b0, dq_tin}, burst ? 32'h0 : 32'hF);
    chk("dqs_din", {28'b0, dqs_din}, burst ? 32'h5 : 32'h0);
    chk("dqs_tin", {28'b0, dqs_tin}, {28'b0, e_tin});
`ifdef WSEQ_ODT_EN
    chk("odt", {31'b0, odt}, {31'b0, burst | pre | post});
`endif
    if (v && e_rdy) begin
      acc_m[n] = 1;
      b0_m[n + int'(wlat) + 2] = 1;
    end
    wreq_m[n] = e_wreq;
    wd_m[n] = d;
    if (n - cyc0 >= 0 && n - cyc0 < 64) begin
      o_wreq[n-cyc0] = wdata_req; o_busy[n-cyc0] = busy; o_rdy[n-cyc0] = cmd_ready;
      o_tin[n-cyc0] = dqs_tin; o_din[n-cyc0] = dqs_din; o_dqt[n-cyc0] = dq_tin;
      o_dq[n-cyc0] = dq_din;
    end
  endtask

  // Asserts reset asynchronously in mid-cycle, checks the outputs right away, then releases reset.
  task automatic do_reset();
    @(posedge clk_div);
    #3;
    rst_n = 0;
    cmd_valid = 0;
    #1;
    chk("rst_dq_din", dq_din, 32'h0);
    chk("rst_dq_tin", {28'b0, dq_tin}, 32'hF);
    chk("rst_dqs_din", {28'b0, dqs_din}, 32'h0);
    chk("rst_dqs_tin", {28'b0, dqs_tin}, 32'hF);
    chk("rst_wdata_req", {31'b0, wdata_req}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
`ifdef WSEQ_ODT_EN
    chk("rst_odt", {31'b0, odt}, 32'h0);
`endif
    repeat (2) @(posedge clk_div);
    clear_model();
    @(negedge clk_div);
    rst_n = 1;
    cyc0 = cyc + 1;
  endtask

  task automatic run_dir(input int id, input int wl, input int a0, input int a1, input int len);
    logic [31:0] d;
    do_reset();
    wlat = WB'(wl);
    for (int r = 0; r < len; r++) begin
      d = (r == a0 + wl + 1) ? P0 : (r == a0 + wl + 2) ? P1 : $urandom;
      step(r == a0 || r == a1, d);
    end
    foreach (vecs[i]) begin
      if (vecs[i].scen == id) begin
        chk($sformatf("s%0d_wreq@%0d", id, vecs[i].rel), {31'b0, o_wreq[vecs[i].rel]},
            {31'b0, vecs[i].wreq});
        chk($sformatf("s%0d_dqs_tin@%0d", id, vecs[i].rel), {28'b0, o_tin[vecs[i].rel]},
            {28'b0, vecs[i].tin});
        chk($sformatf("s%0d_dqs_din@%0d", id, vecs[i].rel), {28'b0, o_din[vecs[i].rel]},
            {28'b0, vecs[i].din});
        chk($sformatf("s%0d_dq_tin@%0d", id, vecs[i].rel), {28'b0, o_dqt[vecs[i].rel]},
            {28'b0, vecs[i].dqt});
        chk($sformatf("s%0d_busy@%0d", id, vecs[i].rel), {31'b0, o_busy[vecs[i].rel]},
            {31'b0, vecs[i].bsy});
        chk($sformatf("s%0d_ready@%0d", id, vecs[i].rel), {31'b0, o_rdy[vecs[i].rel]},
            {31'b0, vecs[i].rdy});
        if (vecs[i].chk_dq)
          chk($sformatf("s%0d_dq_din@%0d", id, vecs[i].rel), o_dq[vecs[i].rel], vecs[i].dq);
      end
    end
  endtask

  initial begin
    // Fields: scen, rel, wreq, dqs_tin, dqs_din, dq_tin, busy, ready, chk_dq, dq
    // Scenario 2: wlat=3, single command at cycle 10.
    vecs.push_back('{2, 11, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{2, 13, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{2, 14, 1'b1, 4'h3, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{2, 15, 1'b1, 4'h0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b1, P0});
    vecs.push_back('{2, 16, 1'b0, 4'h0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b1, P1});
    vecs.push_back('{2, 17, 1'b0, 4'hC, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{2, 18, 1'b0, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0});
    // Scenario 3: wlat=0, commands at cycles 5 and 7, producing gapless bursts.
    vecs.push_back('{3, 6,  1'b1, 4'h3, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{3, 7,  1'b1, 4'h0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{3, 8,  1'b1, 4'h0, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{3, 9,  1'b1, 4'h0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{3, 10, 1'b0, 4'h0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{3, 11, 1'b0, 4'hC, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{3, 12, 1'b0, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0});
    // Scenario 4: wlat=2, commands at cycles 0 and 3, leaving a one-cycle gap at cycle 6.
    vecs.push_back('{4, 3,  1'b1, 4'h3, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{4, 4,  1'b1, 4'h0, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{4, 5,  1'b0, 4'h0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{4, 6,  1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{4, 7,  1'b1, 4'h0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{4, 8,  1'b0, 4'h0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{4, 9,  1'b0, 4'hC, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{4, 10, 1'b0, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0});

    clear_model();
    run_dir(2, 3, 10, -1, 24);
    run_dir(3, 0, 5, 7, 16);
    run_dir(4, 2, 0, 3, 14);

    // Reset in the middle of a burst, then confirm that the block is idle after release.
    do_reset();
    wlat = 4'd3;
    for (int r = 0; r < 16; r++) step(r == 10, $urandom);
    do_reset();
    step(1'b0, $urandom);
    chk("post_rst_ready", {31'b0, cmd_ready}, 32'h1);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);

    // Random traffic at random latencies, checked against the model on every cycle.
    for (int seg = 0; seg < 6; seg++) begin
      wlat = WB'($urandom_range(0, 15));
      for (int r = 0; r < 200; r++) step($urandom_range(0, 99) < 45, $urandom);
      for (int r = 0; r < 24; r++) step(1'b0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
